// File: rtl/uart_tx_fifo_drain.sv
// Drains an upstream FIFO word by word and shifts each out as a start/data/stop serial frame.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the last data bit and stop.
module uart_tx_fifo_drain #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  fifo_read_enable,
   output logic                  tx,
   output logic                  busy
);

   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BitW  = $clog2(DATA_WIDTH);
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      StIdle, StRead, StLoad, StStart, StData, StParity, StStop
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle, StRead, StLoad, StStart, StData, StStop
   } state_e;
`endif

   state_e                state_q, state_d;
   logic [BaudW-1:0]      baud_cnt_q, baud_cnt_d;
   logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  baud_wrap;
   logic                  in_bit;
`ifdef UART_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   assign baud_wrap = (baud_cnt_q == BaudLast);

`ifdef UART_TX_PARITY_EN
   assign in_bit = (state_q == StStart) || (state_q == StData) ||
                   (state_q == StParity) || (state_q == StStop);
`else
   assign in_bit = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
`endif

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      if (in_bit) begin
         baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + 1'b1;
      end else begin
         baud_cnt_d = '0;
      end

      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) state_d = StRead;
         end
         StRead: begin
            state_d = StLoad;
         end
         StLoad: begin
            // FIFO output is valid this cycle, one cycle after the pop strobe.
            state_d   = StStart;
            shift_d   = fifo_data;
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^fifo_data;
`endif
         end
         StStart: begin
            if (baud_wrap) state_d = StData;
         end
         StData: begin
            if (baud_wrap) begin
               if (bit_cnt_q == BitLast) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shift_d   = shift_q >> 1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (baud_wrap) state_d = StStop;
         end
`endif
         StStop: begin
            if (baud_wrap) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // The line level is registered against the next state so tx moves with the state edge.
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign fifo_read_enable = (state_q == StRead);
   assign busy             = (state_q != StIdle);
   assign tx               = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain with CLKS_PER_BIT=4, DATA_WIDTH=8 and a small FIFO model.
// Frame expectations follow UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx_fifo_drain;

   localparam int Cpb = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBits = 11;
`else
   localparam int NBits = 10;
`endif
   localparam int FrameCycles = NBits * Cpb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] fifo_data = 8'h00;
   logic       fifo_empty = 1'b1;
   logic       fifo_read_enable;
   logic       tx;
   logic       busy;

   logic [7:0] fq[$];
   logic       force_ne = 1'b0;

   logic tx_log   [0:255];
   logic rd_log   [0:255];
   logic busy_log [0:255];

   int n_checks = 0;
   int n_pass   = 0;

   uart_tx_fifo_drain #(
      .DATA_WIDTH   (8),
      .CLKS_PER_BIT (Cpb)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .fifo_data        (fifo_data),
      .fifo_empty       (fifo_empty),
      .fifo_read_enable (fifo_read_enable),
      .tx               (tx),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   // One clock; FIFO pops on a strobe seen before the edge, data valid after it.
   task automatic step();
      logic rd;
      rd = fifo_read_enable;
      @(posedge clk);
      #1;
      if (rd && fq.size() > 0) fifo_data = fq.pop_front();
      fifo_empty = (fq.size() == 0) && !force_ne;
   endtask

   task automatic push(input logic [7:0] w);
      fq.push_back(w);
      fifo_empty = (fq.size() == 0) && !force_ne;
   endtask

   // Current cycle is 0; logs cycles 1..n.
   task automatic run_cycles(input int n);
      for (int c = 1; c <= n; c++) begin
         step();
         tx_log[c]   = tx;
         rd_log[c]   = fifo_read_enable;
         busy_log[c] = busy;
      end
   endtask

   function automatic int strobes(input int n);
      int s = 0;
      for (int c = 1; c <= n; c++) if (rd_log[c] === 1'b1) s++;
      return s;
   endfunction

   function automatic logic exp_bit(input logic [7:0] w, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return w[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return ^w;
`endif
      return 1'b1;
   endfunction

   task automatic test_reset();
      int s;
      int lows;
      rst = 1'b1;
      fifo_empty = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_checks++;
      if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++;
      if (fifo_read_enable !== 1'b0)
         $display("FAIL reset_rd: got %b want 0", fifo_read_enable);
      else n_pass++;
      run_cycles(100);
      s = strobes(100);
      lows = 0;
      for (int c = 1; c <= 100; c++) if (tx_log[c] !== 1'b1 || busy_log[c] !== 1'b0) lows++;
      n_checks++;
      if (s !== 0) $display("FAIL empty_strobes: got %0d want 0", s); else n_pass++;
      n_checks++;
      if (lows !== 0) $display("FAIL empty_idle_cycles: got %0d bad cycles want 0", lows);
      else n_pass++;
   endtask

   task automatic test_single_word();
      int s;
      int bad;
      push(8'hA5);
      run_cycles(FrameCycles + 4);
      n_checks++;
      if (rd_log[1] !== 1'b1) $display("FAIL single_rd_c1: got %b want 1", rd_log[1]);
      else n_pass++;
      n_checks++;
      if (rd_log[2] !== 1'b0 || tx_log[2] !== 1'b1)
         $display("FAIL single_c2: got rd=%b tx=%b want rd=0 tx=1", rd_log[2], tx_log[2]);
      else n_pass++;
      for (int k = 0; k < NBits; k++) begin
         bad = 0;
         for (int j = 0; j < Cpb; j++) begin
            if (tx_log[3 + k*Cpb + j] !== exp_bit(8'hA5, k)) bad++;
            if (busy_log[3 + k*Cpb + j] !== 1'b1) bad++;
         end
         n_checks++;
         if (bad != 0)
            $display("FAIL single_bit%0d: got tx=%b want %b (%0d bad samples)",
                     k, tx_log[3 + k*Cpb], exp_bit(8'hA5, k), bad);
         else n_pass++;
      end
      n_checks++;
      if (busy_log[3 + FrameCycles] !== 1'b0 || tx_log[3 + FrameCycles] !== 1'b1)
         $display("FAIL single_end: got busy=%b tx=%b want busy=0 tx=1",
                  busy_log[3 + FrameCycles], tx_log[3 + FrameCycles]);
      else n_pass++;
      s = strobes(FrameCycles + 4);
      n_checks++;
      if (s !== 1) $display("FAIL single_strobes: got %0d want 1", s); else n_pass++;
   endtask

   task automatic test_parity();
      int bad;
      push(8'h07);
      run_cycles(FrameCycles + 4);
      // 0x07 LSB first: 1,1,1,0,0,0,0,0
      bad = 0;
      for (int j = 0; j < 3*Cpb; j++) if (tx_log[3 + Cpb + j] !== 1'b1) bad++;
      for (int j = 0; j < 5*Cpb; j++) if (tx_log[3 + 4*Cpb + j] !== 1'b0) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL parity_data: got %0d bad samples want 0", bad); else n_pass++;
`ifdef UART_TX_PARITY_EN
      n_checks++;
      if (tx_log[3 + 9*Cpb] !== 1'b1)
         $display("FAIL parity_bit: got %b want 1", tx_log[3 + 9*Cpb]);
      else n_pass++;
      n_checks++;
      if (busy_log[3 + 44 - 1] !== 1'b1 || busy_log[3 + 44] !== 1'b0)
         $display("FAIL parity_len: got busy=%b,%b want 1,0", busy_log[46], busy_log[47]);
      else n_pass++;
`else
      n_checks++;
      if (tx_log[3 + 9*Cpb] !== 1'b1)
         $display("FAIL noparity_stop: got %b want 1", tx_log[3 + 9*Cpb]);
      else n_pass++;
      n_checks++;
      if (busy_log[3 + 40 - 1] !== 1'b1 || busy_log[3 + 40] !== 1'b0)
         $display("FAIL noparity_len: got busy=%b,%b want 1,0", busy_log[42], busy_log[43]);
      else n_pass++;
`endif
   endtask

   task automatic test_back_to_back();
      int e;
      int n;
      int s;
      int highs;
      int bad;
      e = 3 + (NBits - 1) * Cpb;
      n = e + 7 + FrameCycles + 2;
      push(8'h00);
      push(8'hFF);
      run_cycles(n);
      s = strobes(n);
      n_checks++;
      if (s !== 2) $display("FAIL b2b_strobes: got %0d want 2", s); else n_pass++;
      n_checks++;
      if (rd_log[1] !== 1'b1 || rd_log[e + 5] !== 1'b1)
         $display("FAIL b2b_strobe_cycles: got %b,%b want 1,1", rd_log[1], rd_log[e + 5]);
      else n_pass++;
      highs = 0;
      for (int c = e; c < e + 7; c++) if (tx_log[c] === 1'b1) highs++;
      n_checks++;
      if (highs !== 7 || tx_log[e - 1] !== 1'b0 || tx_log[e + 7] !== 1'b0)
         $display("FAIL b2b_gap: got %0d highs (edges %b,%b) want 7 (0,0)",
                  highs, tx_log[e - 1], tx_log[e + 7]);
      else n_pass++;
      bad = 0;
      for (int c = 3; c < 3 + FrameCycles; c++)
         if (tx_log[c] !== exp_bit(8'h00, (c - 3) / Cpb)) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL b2b_frame1: got %0d bad samples want 0", bad); else n_pass++;
      bad = 0;
      for (int c = e + 7; c < e + 7 + FrameCycles; c++)
         if (tx_log[c] !== exp_bit(8'hFF, (c - e - 7) / Cpb)) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL b2b_frame2: got %0d bad samples want 0", bad); else n_pass++;
   endtask

   task automatic test_mid_reset();
      int bad;
      int s;
      push(8'h3C);
      push(8'h5A);
      run_cycles(20);
      bad = 0;
      for (int c = 3; c <= 20; c++) if (tx_log[c] !== exp_bit(8'h3C, (c - 3) / Cpb)) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL mrst_prefix: got %0d bad samples want 0", bad); else n_pass++;
      rst = 1'b1;
      step();
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read_enable !== 1'b0)
         $display("FAIL mrst_after: got tx=%b busy=%b rd=%b want 1,0,0",
                  tx, busy, fifo_read_enable);
      else n_pass++;
      rst = 1'b0;
      run_cycles(FrameCycles + 4);
      s = strobes(FrameCycles + 4);
      n_checks++;
      if (s !== 1 || rd_log[1] !== 1'b1)
         $display("FAIL mrst_refetch: got %0d strobes rd1=%b want 1,1", s, rd_log[1]);
      else n_pass++;
      bad = 0;
      for (int c = 3; c < 3 + FrameCycles; c++)
         if (tx_log[c] !== exp_bit(8'h5A, (c - 3) / Cpb)) bad++;
      n_checks++;
      if (bad != 0 || tx_log[2] !== 1'b1)
         $display("FAIL mrst_frame: got %0d bad samples want 0", bad);
      else n_pass++;
      n_checks++;
      if (busy_log[3 + FrameCycles] !== 1'b0)
         $display("FAIL mrst_end_busy: got %b want 0", busy_log[3 + FrameCycles]);
      else n_pass++;
   endtask

   task automatic test_empty_stop();
      int sp;
      int s;
      int highs;
      sp = 3 + (NBits - 1) * Cpb;
      force_ne = 1'b1;
      push(8'h81);
      run_cycles(sp + 1);
      s = strobes(sp + 1);
      n_checks++;
      if (s !== 1) $display("FAIL estop_midframe_strobes: got %0d want 1", s); else n_pass++;
      force_ne = 1'b0;
      fifo_empty = 1'b1;
      run_cycles(40);
      s = strobes(40);
      n_checks++;
      if (s !== 0) $display("FAIL estop_strobes: got %0d want 0", s); else n_pass++;
      highs = 0;
      for (int c = 1; c <= 40; c++) if (tx_log[c] === 1'b1) highs++;
      n_checks++;
      if (highs !== 40) $display("FAIL estop_tx_high: got %0d want 40", highs); else n_pass++;
      n_checks++;
      if (busy_log[2] !== 1'b1 || busy_log[3] !== 1'b0 || busy_log[40] !== 1'b0)
         $display("FAIL estop_busy: got %b,%b,%b want 1,0,0",
                  busy_log[2], busy_log[3], busy_log[40]);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_parity();
      test_back_to_back();
      test_mid_reset();
      test_empty_stop();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
